// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Control states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand widths.
  localparam int W_MIN = 1;
  localparam int W_MAX = 32;

  // Bit counter width: enough to count 0..W-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used as the serial adder's arithmetic cell.
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  // Sum and majority carry.
  always_comb begin
    o_s  = i_a ^ i_b ^ i_c;
    o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: W-bit operands in, (W+1)-bit sum out after W
// cycles, one bit per cycle LSB first through a single full-adder cell.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum
);

  localparam int CW = cnt_width(W);

  generate
    if (W < W_MIN || W > W_MAX) begin : g_bad_width
      $error("serial_adder: W out of range 1..32");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a_sr;
  logic [W-1:0]    r_b_sr;
  logic [W:0]      r_sum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_sub;

  logic            w_accept;
  logic            w_last;
  logic            w_sub_in;
  logic            w_b_bit;
  logic            w_s;
  logic            w_co;
  logic [W-1:0]    w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub_in = in_sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1: the B bit is inverted here, the +1 is the carry preset.
  assign w_b_bit = r_b_sr[0] ^ r_sub;
  assign w_last  = (r_cnt == CW'(W - 1));
  assign out_sum = r_sum;

  serial_fa_cell u_fa (
    .i_a  (r_a_sr[0]),
    .i_b  (w_b_bit),
    .i_c  (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // New sum bit enters at the top so that after W shifts bit 0 is the LSB.
  generate
    if (W == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      assign w_res_next = {w_s, r_sum[W-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs; in_ready depends on state only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: load on acceptance, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sub   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= in_a;
      r_b_sr  <= in_b;
      r_sum   <= '0;
      r_carry <= w_sub_in;
      r_cnt   <= '0;
      r_sub   <= w_sub_in;
    end else if (r_state == RUN) begin
      r_a_sr         <= r_a_sr >> 1;
      r_b_sr         <= r_b_sr >> 1;
      r_carry        <= w_co;
      r_cnt          <= r_cnt + CW'(1);
      r_sum[W-1:0]   <= w_res_next;
      // Final carry is the carry out for add; inverted it is the sign for subtract.
      if (w_last) r_sum[W] <= w_co ^ r_sub;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at W=1, W=2 and W=4.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, sub1;
  logic [0:0] a1, b1;
  logic [1:0] sum1;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, sub2;
  logic [1:0] a2, b2;
  logic [2:0] sum2;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, sub4;
  logic [3:0] a4, b4;
  logic [4:0] sum4;

  logic [32:0] q1[$];
  logic [32:0] q2[$];
  logic [32:0] q4[$];

  serial_adder #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(sum1)
  );

  serial_adder #(.W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(a2), .in_b(b2),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub2),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(sum2)
  );

  serial_adder #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(a4), .in_b(b4),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(sum4)
  );

  function automatic int model(input int w, input int a, input int b, input bit sub);
    int m;
    m = (1 << (w + 1)) - 1;
    return sub ? ((a - b) & m) : ((a + b) & m);
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboards: push the modelled sum at each input handshake, pop at each output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid1 && in_ready1) q1.push_back(33'(model(1, int'(a1), int'(b1), sub1)));
      if (in_valid2 && in_ready2) q2.push_back(33'(model(2, int'(a2), int'(b2), sub2)));
      if (in_valid4 && in_ready4) q4.push_back(33'(model(4, int'(a4), int'(b4), sub4)));
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) chk("sb1_unexpected", 33'(sum1), 33'h1ffffffff);
        else                chk("sb1", 33'(sum1), q1.pop_front());
      end
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) chk("sb2_unexpected", 33'(sum2), 33'h1ffffffff);
        else                chk("sb2", 33'(sum2), q2.pop_front());
      end
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) chk("sb4_unexpected", 33'(sum4), 33'h1ffffffff);
        else                chk("sb4", 33'(sum4), q4.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int last_acc;
    int n;
    int pulses;
    int ta [3];
    int tb [3];
    int te [3];

    rst_n = 1'b0;
    in_valid1 = 0; a1 = '0; b1 = '0; sub1 = 0; out_ready1 = 1;
    in_valid2 = 0; a2 = '0; b2 = '0; sub2 = 0; out_ready2 = 1;
    in_valid4 = 0; a4 = '0; b4 = '0; sub4 = 0; out_ready4 = 1;
    tick(); tick(); tick();

    // Reset state.
    chk("rst_in_ready2",  33'(in_ready2),  33'd1);
    chk("rst_out_valid2", 33'(out_valid2), 33'd0);
    chk("rst_out_sum2",   33'(sum2),       33'd0);
    chk("rst_in_ready4",  33'(in_ready4),  33'd1);
    chk("rst_out_valid1", 33'(out_valid1), 33'd0);
    rst_n = 1'b1;
    tick();

    // W=2: 3+3, result valid exactly W cycles after acceptance.
    a2 = 2'd3; b2 = 2'd3; in_valid2 = 1;
    chk("t1_in_ready_before", 33'(in_ready2), 33'd1);
    tick();
    in_valid2 = 0;
    chk("t1_in_ready_run",  33'(in_ready2),  33'd0);
    chk("t1_out_valid_k0",  33'(out_valid2), 33'd0);
    tick();
    chk("t1_out_valid_k1",  33'(out_valid2), 33'd0);
    tick();
    chk("t1_out_valid_k2",  33'(out_valid2), 33'd1);
    chk("t1_sum",           33'(sum2),       33'b110);
    tick();
    chk("t1_back_idle",     33'(in_ready2),  33'd1);
    chk("t1_valid_dropped", 33'(out_valid2), 33'd0);

    // W=2: all 16 pairs back-to-back with in_valid held high.
    // Period is W RUN cycles + one DONE + one IDLE.
    in_valid2 = 1;
    last_acc  = 0;
    pulses    = 0;
    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2);
      b2 = 2'(i & 3);
      n = 0;
      while (!in_ready2 && n < 8) begin
        tick();
        n++;
      end
      chk("sweep_ready_seen", 33'(in_ready2), 33'd1);
      if (i > 0) chk("sweep_spacing", 33'(cyc - last_acc), 33'd4);
      last_acc = cyc;
      pulses++;
      tick();
      chk("sweep_ready_pulse", 33'(in_ready2), 33'd0);
    end
    in_valid2 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("sweep_pulses", 33'(pulses), 33'd16);

    // W=2: 2+1 with consumer stalled for 5 cycles.
    out_ready2 = 0;
    a2 = 2'd2; b2 = 2'd1; in_valid2 = 1;
    tick();
    in_valid2 = 0;
    a2 = 2'd0; b2 = 2'd0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 33'(out_valid2), 33'd1);
      chk("hold_sum",   33'(sum2),       33'b011);
      chk("hold_ready", 33'(in_ready2),  33'd0);
      tick();
    end
    out_ready2 = 1;
    chk("hold_release_valid", 33'(out_valid2), 33'd1);
    tick();
    chk("hold_idle_ready", 33'(in_ready2),  33'd1);
    chk("hold_idle_valid", 33'(out_valid2), 33'd0);

    // W=4: 15+15 aborted by reset after 2 RUN cycles, then 1+2.
    a4 = 4'd15; b4 = 4'd15; in_valid4 = 1;
    tick();
    in_valid4 = 0;
    tick(); tick();
    chk("abort_running", 33'(in_ready4), 33'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 33'(out_valid4), 33'd0);
    chk("abort_in_ready",  33'(in_ready4),  33'd1);
    chk("abort_sum",       33'(sum4),       33'd0);
    q4.delete();
    tick();
    rst_n = 1'b1;
    tick();
    a4 = 4'd1; b4 = 4'd2; in_valid4 = 1;
    tick();
    in_valid4 = 0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      tick();
      n++;
    end
    chk("w4_latency", 33'(n), 33'd4);
    chk("w4_sum",     33'(sum4), 33'b00011);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    // W=2 subtraction, in_sub changed after acceptance must be ignored.
    ta = '{1, 3, 2};
    tb = '{3, 1, 2};
    te = '{6, 2, 0};
    for (int i = 0; i < 3; i++) begin
      a2 = 2'(ta[i]); b2 = 2'(tb[i]); sub2 = 1; in_valid2 = 1;
      tick();
      in_valid2 = 0; sub2 = 0;
      tick(); tick();
      chk("sub_valid", 33'(out_valid2), 33'd1);
      chk("sub_sum",   33'(sum2),       33'(te[i]));
      tick();
    end
`endif

    // W=1: operands changed during RUN are ignored; RUN lasts one cycle.
    ta = '{1, 1, 0};
    tb = '{1, 0, 0};
    te = '{2, 1, 0};
    for (int i = 0; i < 3; i++) begin
      a1 = 1'(ta[i]); b1 = 1'(tb[i]); in_valid1 = 1;
      tick();
      in_valid1 = 0;
      a1 = ~a1; b1 = ~b1;
      chk("w1_run_valid", 33'(out_valid1), 33'd0);
      tick();
      chk("w1_valid", 33'(out_valid1), 33'd1);
      chk("w1_sum",   33'(sum1),       33'(te[i]));
      tick();
      chk("w1_idle",  33'(in_ready1),  33'd1);
    end

    tick(); tick();
    chk("sb1_drained", 33'(q1.size()), 33'd0);
    chk("sb2_drained", 33'(q2.size()), 33'd0);
    chk("sb4_drained", 33'(q4.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
